anchor_scan_gen: RTL
====================

Name: anchor_scan_gen

Overview:
- Produces the sequence of window anchor addresses that feeds the 25-point window address generator's anchor input, one anchor per accepted handshake.
- Raster-scans a V_IMAGE_LEN x H_IMAGE_LEN image stored row-major from BASE_ADDR, with a configurable stride, until all valid window positions are issued.
- Replaces the external anchor ROM: scan paths are computed, not stored.

Parameters:
- H_IMAGE_LEN, 35, image width in words (row pitch)
- V_IMAGE_LEN, 35, image height in rows
- H_WINDOW_LEN, 5, window width
- V_WINDOW_LEN, 5, window height
- STRIDE, 1, anchor step, both directions (>=1)
- BASE_ADDR, 0, address of image pixel (0,0)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to begin a scan; ignored unless IDLE
- pause  in  1  freezes the scan while high
- anchor_ready  in  1  downstream accepts the current anchor
- anchor_addr_out  out  32  current anchor address
- anchor_valid  out  1  anchor_addr_out is valid
- row_idx  out  16  output-row index of the current anchor
- col_idx  out  16  output-column index of the current anchor
- busy  out  1  high in SCAN state
- done  out  1  one-cycle pulse after the last anchor transfers

Behaviour:
- Derived constants: H_OUT = (H_IMAGE_LEN-H_WINDOW_LEN)/STRIDE+1 and V_OUT = (V_IMAGE_LEN-V_WINDOW_LEN)/STRIDE+1, both integer division. Default is 31x31, 961 anchors.
- Address arithmetic is unsigned 32-bit and wraps modulo 2^32. Multiplication is not allowed in the datapath; only incremental adds are used.
- FSM states are IDLE, SCAN and DONE.
- Reset state: IDLE; anchor_addr_out=0, row_idx=0, col_idx=0, anchor_valid=0, busy=0, done=0.
- IDLE + start: next edge loads row_idx=0, col_idx=0, anchor_addr_out=BASE_ADDR and a row-start register=BASE_ADDR, then enters SCAN.
- Latency: anchor_valid rises on the first cycle after start is sampled.
- anchor_valid = (state==SCAN) && !pause. It never depends on anchor_ready.
- Transfer occurs when anchor_valid && anchor_ready at a rising edge.
- On a transfer that is not the last anchor:
  - If col_idx < H_OUT-1: col_idx+1, anchor_addr_out += STRIDE.
  - Otherwise: col_idx=0, row_idx+1, row-start += STRIDE*H_IMAGE_LEN (a constant), anchor_addr_out = new row-start.
- Last anchor is row_idx=V_OUT-1 and col_idx=H_OUT-1. Its transfer moves the FSM to DONE. anchor_addr_out, row_idx and col_idx hold their values.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
- pause: while high, no transfer occurs and all registers hold. anchor_ready is ignored during pause. The scan resumes at the same anchor.
- Stall (anchor_ready=0): outputs hold, and anchor_addr_out stays stable while anchor_valid=1.
- start while in SCAN or DONE is ignored; there is no restart mid-scan.
- start and pause in the same cycle in IDLE: start is accepted, and anchor_valid stays low until pause falls.
- rst_n asserted mid-scan: all outputs and state return to reset values immediately (asynchronous). No done pulse is produced.

Optional Feature:
- Macro: ANCHOR_SNAKE_EN.
- When defined, the scan is serpentine:
  - Even rows traverse col 0 up to H_OUT-1 with anchor_addr_out += STRIDE.
  - Odd rows start at col_idx=H_OUT-1 with address row-start + (H_OUT-1)*STRIDE (a constant), then decrement col_idx and subtract STRIDE.
  - The last anchor becomes row V_OUT-1 at col H_OUT-1 when V_OUT is odd, or col 0 when V_OUT is even.
- When not defined, the scan is plain raster as described above. No extra logic is generated.

Test Plan:
- Default parameters, start, anchor_ready=1 constant: exactly 961 transfers on consecutive cycles, then done pulses once and busy falls.
  - Transfers 0, 30, 31 and 960 carry addresses 0, 30, 35 and 1080.
  - Transfer 960 has row_idx=30, col_idx=30.
- STRIDE=2, BASE_ADDR=100, 9x9 image, 3x3 window (H_OUT=V_OUT=4): addresses are 100,102,104,106,118,…,160, 16 in total, then done.
- Backpressure: anchor_ready toggles every cycle, and pause is held high for 5 cycles mid-row.
  - anchor_valid is low exactly during pause.
  - No anchor is skipped or duplicated, and the address holds throughout stalls.
- Second start issued during SCAN plus assertion of rst_n at transfer 500:
  - The extra start has no effect.
  - Reset clears all outputs asynchronously; a new start then restarts from BASE_ADDR.
- ANCHOR_SNAKE_EN, default parameters:
  - Transfers 30, 31 and 32 carry addresses 30, 65 and 64.
  - Final transfer is address 1080 at row 30, col 30.
  - Total count is still 961.

Source files
------------

// File: rtl/anchor_scan_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : anchor_scan_gen_if
//  Description : Control and anchor handshake bundle for anchor_scan_gen.
//                master = the anchor generator, slave = controller/consumer.
//  Signals     : start, pause, anchor_ready          (to generator)
//                anchor_addr_out[31:0], anchor_valid,
//                row_idx[15:0], col_idx[15:0],
//                busy, done                           (from generator)
//  Revision    : 1.0  initial release
// ============================================================================
interface anchor_scan_gen_if;
  logic        start;
  logic        pause;
  logic        anchor_ready;
  logic [31:0] anchor_addr_out;
  logic        anchor_valid;
  logic [15:0] row_idx;
  logic [15:0] col_idx;
  logic        busy;
  logic        done;

  modport master (
    input  start, pause, anchor_ready,
    output anchor_addr_out, anchor_valid, row_idx, col_idx, busy, done
  );

  modport slave (
    output start, pause, anchor_ready,
    input  anchor_addr_out, anchor_valid, row_idx, col_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/anchor_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : anchor_scan_gen
//  Description : Computes the window anchor address sequence for a raster
//                scan of a V_IMAGE_LEN x H_IMAGE_LEN row-major image starting
//                at BASE_ADDR, one anchor per valid/ready transfer. Addresses
//                are built from incremental adds only (no multipliers).
//  Ports       : clk              rising-edge clock
//                rst_n            asynchronous active-low reset
//                bus (master)     start/pause/anchor_ready in;
//                                 anchor_addr_out, anchor_valid, row_idx,
//                                 col_idx, busy, done out
//  Option      : ANCHOR_SNAKE_EN  serpentine scan (odd rows run right-to-left)
//  Revision    : 1.0  initial release
// ============================================================================
module anchor_scan_gen #(
  parameter int unsigned H_IMAGE_LEN  = 35,
  parameter int unsigned V_IMAGE_LEN  = 35,
  parameter int unsigned H_WINDOW_LEN = 5,
  parameter int unsigned V_WINDOW_LEN = 5,
  parameter int unsigned STRIDE       = 1,
  parameter logic [31:0] BASE_ADDR    = 32'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  anchor_scan_gen_if.master  bus
);

  // Output grid size
  localparam int unsigned c_h_out = (H_IMAGE_LEN - H_WINDOW_LEN) / STRIDE + 1;
  localparam int unsigned c_v_out = (V_IMAGE_LEN - V_WINDOW_LEN) / STRIDE + 1;

  localparam logic [15:0] c_col_last = 16'(c_h_out - 1);
  localparam logic [15:0] c_row_last = 16'(c_v_out - 1);
  localparam logic [31:0] c_stride   = 32'(STRIDE);
  // Address distance between the first anchors of consecutive output rows
  localparam logic [31:0] c_row_step = 32'(STRIDE * H_IMAGE_LEN);
`ifdef ANCHOR_SNAKE_EN
  // Offset of the right-most anchor from its row start (entry point of odd rows)
  localparam logic [31:0] c_rev_off  = 32'((c_h_out - 1) * STRIDE);
`endif

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_scan = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_row_start;
  logic [15:0] r_row;
  logic [15:0] r_col;

  logic        w_valid;
  logic        w_xfer;
  logic        w_row_end;
  logic        w_last;
  logic [31:0] w_next_addr;
  logic [31:0] w_next_row_start;
  logic [15:0] w_next_row;
  logic [15:0] w_next_col;

  assign w_valid = (r_state == c_scan) && !bus.pause;
  assign w_xfer  = w_valid && bus.anchor_ready;

`ifdef ANCHOR_SNAKE_EN
  // Odd rows run right-to-left, so their end is column 0
  assign w_row_end = r_row[0] ? (r_col == 16'd0) : (r_col == c_col_last);
`else
  assign w_row_end = (r_col == c_col_last);
`endif
  assign w_last = (r_row == c_row_last) && w_row_end;

  // Next anchor position after a (non-final) transfer
  always_comb begin
    w_next_addr      = r_addr;
    w_next_row_start = r_row_start;
    w_next_row       = r_row;
    w_next_col       = r_col;
    if (w_row_end) begin
      w_next_row_start = r_row_start + c_row_step;
      w_next_row       = r_row + 16'd1;
`ifdef ANCHOR_SNAKE_EN
      if (r_row[0]) begin
        // odd -> even: restart at the left edge
        w_next_col  = 16'd0;
        w_next_addr = r_row_start + c_row_step;
      end else begin
        // even -> odd: enter at the right edge
        w_next_col  = c_col_last;
        w_next_addr = r_row_start + c_row_step + c_rev_off;
      end
`else
      w_next_col  = 16'd0;
      w_next_addr = r_row_start + c_row_step;
`endif
    end else begin
`ifdef ANCHOR_SNAKE_EN
      if (r_row[0]) begin
        w_next_col  = r_col - 16'd1;
        w_next_addr = r_addr - c_stride;
      end else begin
        w_next_col  = r_col + 16'd1;
        w_next_addr = r_addr + c_stride;
      end
`else
      w_next_col  = r_col + 16'd1;
      w_next_addr = r_addr + c_stride;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_addr      <= 32'd0;
      r_row_start <= 32'd0;
      r_row       <= 16'd0;
      r_col       <= 16'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_state     <= c_scan;
            r_addr      <= BASE_ADDR;
            r_row_start <= BASE_ADDR;
            r_row       <= 16'd0;
            r_col       <= 16'd0;
          end
        end
        c_scan: begin
          if (w_xfer) begin
            if (w_last) begin
              // Final anchor: position registers hold their values
              r_state <= c_done;
            end else begin
              r_addr      <= w_next_addr;
              r_row_start <= w_next_row_start;
              r_row       <= w_next_row;
              r_col       <= w_next_col;
            end
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign bus.anchor_addr_out = r_addr;
  assign bus.anchor_valid    = w_valid;
  assign bus.row_idx         = r_row;
  assign bus.col_idx         = r_col;
  assign bus.busy            = (r_state == c_scan);
  assign bus.done            = (r_state == c_done);

endmodule
`default_nettype wire
